// File: rtl/axi_rd_master_mo.sv
// ---------------------------------------------------------------------------
// axi_rd_master_mo
// AXI4 read-channel master that keeps up to MAX_OUTST bursts in flight.
// Commands arrive on a valid/ready port and go out on AR. ARVALID and the
// payload are held until ARREADY. Each accepted command is pushed as {id, len}
// into a tracking FIFO. Every accepted R beat is checked against the FIFO head
// and forwarded through a one-entry output register onto the rsp_* stream.
//
// Ports
//   ACLK, ARESETn                 clock, async active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_id/addr/len/size/burst    command payload (AR fields)
//   ARID..ARBURST, ARVALID        registered AR payload and valid
//   ARREADY                       AR handshake input
//   RID/RDATA/RRESP/RLAST/RVALID  R channel inputs
//   RREADY                        R acceptance (free output slot)
//   rsp_valid/rsp_ready           response beat handshake
//   rsp_id/data/resp/last         registered response beat
//   outst_cnt                     commands accepted but not yet completed
//   proto_err                     sticky protocol error
//   err_clear                     clears proto_err and resp_err_cnt
//   resp_err_cnt                  saturating count of SLVERR/DECERR beats
// ---------------------------------------------------------------------------
module axi_rd_master_mo #(
   parameter int ID_W      = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_OUTST = 4,
   parameter int ERRCNT_W  = 16
) (
   input  logic                           ACLK,
   input  logic                           ARESETn,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [ID_W-1:0]                cmd_id,
   input  logic [ADDR_W-1:0]              cmd_addr,
   input  logic [7:0]                     cmd_len,
   input  logic [2:0]                     cmd_size,
   input  logic [1:0]                     cmd_burst,
   output logic [ID_W-1:0]                ARID,
   output logic [ADDR_W-1:0]              ARADDR,
   output logic [7:0]                     ARLEN,
   output logic [2:0]                     ARSIZE,
   output logic [1:0]                     ARBURST,
   output logic                           ARVALID,
   input  logic                           ARREADY,
   input  logic [ID_W-1:0]                RID,
   input  logic [DATA_W-1:0]              RDATA,
   input  logic [1:0]                     RRESP,
   input  logic                           RLAST,
   input  logic                           RVALID,
   output logic                           RREADY,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [ID_W-1:0]                rsp_id,
   output logic [DATA_W-1:0]              rsp_data,
   output logic [1:0]                     rsp_resp,
   output logic                           rsp_last,
   output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
   output logic                           proto_err,
   input  logic                           err_clear,
   output logic [ERRCNT_W-1:0]            resp_err_cnt
);

   localparam int CNT_W = $clog2(MAX_OUTST + 1);
   localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam logic [CNT_W-1:0]    MAX_CNT  = CNT_W'(MAX_OUTST);
   localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(MAX_OUTST - 1);
   localparam logic [ERRCNT_W-1:0] ERR_MAX  = {ERRCNT_W{1'b1}};

   typedef enum logic [0:0] {AR_IDLE = 1'b0, AR_BUSY = 1'b1} ar_state_t;

   ar_state_t             ar_state_r;
   logic [ID_W-1:0]       fifo_id_r  [MAX_OUTST];
   logic [7:0]            fifo_len_r [MAX_OUTST];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [CNT_W-1:0]      outst_cnt_r;
   logic [7:0]            beat_cnt_r;
   logic                  proto_err_r;
   logic [ERRCNT_W-1:0]   resp_err_cnt_r;

   logic                  cmd_acc_s;
   logic                  r_acc_s;
   logic                  fifo_empty_s;
   logic [ID_W-1:0]       head_id_s;
   logic [7:0]            head_len_s;
   logic                  burst_end_s;
   logic                  proto_set_s;

   // Wrap-around increment; depth need not fill the pointer range when MAX_OUTST=1.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == LAST_PTR) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   assign cmd_ready    = (ar_state_r == AR_IDLE) && (outst_cnt_r < MAX_CNT);
   assign cmd_acc_s    = cmd_valid && cmd_ready;
   assign RREADY       = !rsp_valid || rsp_ready;
   assign r_acc_s      = RVALID && RREADY;
   assign fifo_empty_s = (outst_cnt_r == {CNT_W{1'b0}});
   assign head_id_s    = fifo_id_r[rd_ptr_r];
   assign head_len_s   = fifo_len_r[rd_ptr_r];
   // An overrun (no RLAST at the final beat) also closes the burst to stay in step.
   assign burst_end_s  = r_acc_s && !fifo_empty_s && (RLAST || (beat_cnt_r == head_len_s));
   assign outst_cnt    = outst_cnt_r;
   assign proto_err    = proto_err_r;
   assign resp_err_cnt = resp_err_cnt_r;

   // Protocol check of the accepted beat against the tracking FIFO head.
   always_comb begin
      proto_set_s = 1'b0;
      if (r_acc_s) begin
         if (fifo_empty_s) begin
            proto_set_s = 1'b1;
         end else begin
            proto_set_s = (RID != head_id_s) ||
                          (RLAST && (beat_cnt_r != head_len_s)) ||
                          (!RLAST && (beat_cnt_r == head_len_s));
         end
      end else begin
         proto_set_s = 1'b0;
      end
   end

   // AR channel FSM with registered ARVALID and payload.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         ar_state_r <= AR_IDLE;
         ARVALID    <= 1'b0;
         ARID       <= {ID_W{1'b0}};
         ARADDR     <= {ADDR_W{1'b0}};
         ARLEN      <= 8'd0;
         ARSIZE     <= 3'd0;
         ARBURST    <= 2'd0;
      end else begin
         case (ar_state_r)
            AR_IDLE: begin
               if (cmd_acc_s) begin
                  ar_state_r <= AR_BUSY;
                  ARVALID    <= 1'b1;
                  ARID       <= cmd_id;
                  ARADDR     <= cmd_addr;
                  ARLEN      <= cmd_len;
                  ARSIZE     <= cmd_size;
                  ARBURST    <= cmd_burst;
               end
            end
            AR_BUSY: begin
               if (ARREADY) begin
                  ar_state_r <= AR_IDLE;
                  ARVALID    <= 1'b0;
               end
            end
            default: begin
               ar_state_r <= AR_IDLE;
               ARVALID    <= 1'b0;
            end
         endcase
      end
   end

   // Tracking FIFO, outstanding count and beat counter of the head burst.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         for (int i = 0; i < MAX_OUTST; i++) begin
            fifo_id_r[i]  <= {ID_W{1'b0}};
            fifo_len_r[i] <= 8'd0;
         end
         wr_ptr_r    <= {PTR_W{1'b0}};
         rd_ptr_r    <= {PTR_W{1'b0}};
         outst_cnt_r <= {CNT_W{1'b0}};
         beat_cnt_r  <= 8'd0;
      end else begin
         if (cmd_acc_s) begin
            fifo_id_r[wr_ptr_r]  <= cmd_id;
            fifo_len_r[wr_ptr_r] <= cmd_len;
            wr_ptr_r             <= ptr_inc(wr_ptr_r);
         end
         if (burst_end_s) begin
            rd_ptr_r   <= ptr_inc(rd_ptr_r);
            beat_cnt_r <= 8'd0;
         end else if (r_acc_s && !fifo_empty_s) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
         end
         case ({cmd_acc_s, burst_end_s})
            2'b10:   outst_cnt_r <= outst_cnt_r + CNT_W'(1);
            2'b01:   outst_cnt_r <= outst_cnt_r - CNT_W'(1);
            default: outst_cnt_r <= outst_cnt_r;
         endcase
      end
   end

   // One-entry response register; RREADY opens whenever it is empty or draining.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         rsp_valid <= 1'b0;
         rsp_id    <= {ID_W{1'b0}};
         rsp_data  <= {DATA_W{1'b0}};
         rsp_resp  <= 2'd0;
         rsp_last  <= 1'b0;
      end else if (r_acc_s) begin
         rsp_valid <= 1'b1;
         rsp_id    <= RID;
         rsp_data  <= RDATA;
         rsp_resp  <= RRESP;
         rsp_last  <= RLAST;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   // Sticky protocol error and saturating error-response counter; clear wins.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         proto_err_r    <= 1'b0;
         resp_err_cnt_r <= {ERRCNT_W{1'b0}};
      end else if (err_clear) begin
         proto_err_r    <= 1'b0;
         resp_err_cnt_r <= {ERRCNT_W{1'b0}};
      end else begin
         if (proto_set_s) begin
            proto_err_r <= 1'b1;
         end
         if (r_acc_s && RRESP[1] && (resp_err_cnt_r != ERR_MAX)) begin
            resp_err_cnt_r <= resp_err_cnt_r + ERRCNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_axi_rd_master_mo.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_master_mo
// Directed scenarios with literal expectations followed by randomized traffic.
// A queue-based model of the read master is compared against the DUT on every
// cycle. A second instance with ERRCNT_W=2 shares all inputs so that counter
// saturation can be observed.
// ---------------------------------------------------------------------------
module tb_axi_rd_master_mo;

   localparam int ID_W      = 4;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int MAX_OUTST = 4;

   typedef struct {
      logic [ID_W-1:0] id;
      logic [7:0]      len;
   } burst_t;

   logic ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   logic              ARESETn;
   logic              cmd_valid;
   logic [ID_W-1:0]   cmd_id;
   logic [ADDR_W-1:0] cmd_addr;
   logic [7:0]        cmd_len;
   logic [2:0]        cmd_size;
   logic [1:0]        cmd_burst;
   logic              ARREADY;
   logic [ID_W-1:0]   RID;
   logic [DATA_W-1:0] RDATA;
   logic [1:0]        RRESP;
   logic              RLAST;
   logic              RVALID;
   logic              rsp_ready;
   logic              err_clear;

   logic              cmd_ready, ARVALID, RREADY, rsp_valid, rsp_last, proto_err;
   logic [ID_W-1:0]   ARID, rsp_id;
   logic [ADDR_W-1:0] ARADDR;
   logic [7:0]        ARLEN;
   logic [2:0]        ARSIZE;
   logic [1:0]        ARBURST, rsp_resp;
   logic [DATA_W-1:0] rsp_data;
   logic [2:0]        outst_cnt;
   logic [15:0]       resp_err_cnt;

   logic              s_cmd_ready, s_ARVALID, s_RREADY, s_rsp_valid, s_rsp_last, s_proto_err;
   logic [ID_W-1:0]   s_ARID, s_rsp_id;
   logic [ADDR_W-1:0] s_ARADDR;
   logic [7:0]        s_ARLEN;
   logic [2:0]        s_ARSIZE;
   logic [1:0]        s_ARBURST, s_rsp_resp;
   logic [DATA_W-1:0] s_rsp_data;
   logic [2:0]        s_outst_cnt;
   logic [1:0]        s_resp_err_cnt;

   axi_rd_master_mo #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                      .MAX_OUTST(MAX_OUTST), .ERRCNT_W(16)) u_dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
      .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_resp(rsp_resp), .rsp_last(rsp_last), .outst_cnt(outst_cnt),
      .proto_err(proto_err), .err_clear(err_clear), .resp_err_cnt(resp_err_cnt)
   );

   axi_rd_master_mo #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                      .MAX_OUTST(MAX_OUTST), .ERRCNT_W(2)) u_sat (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
      .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
      .ARID(s_ARID), .ARADDR(s_ARADDR), .ARLEN(s_ARLEN), .ARSIZE(s_ARSIZE), .ARBURST(s_ARBURST),
      .ARVALID(s_ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(s_RREADY),
      .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_data(s_rsp_data),
      .rsp_resp(s_rsp_resp), .rsp_last(s_rsp_last), .outst_cnt(s_outst_cnt),
      .proto_err(s_proto_err), .err_clear(err_clear), .resp_err_cnt(s_resp_err_cnt)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // model state
   burst_t            mq[$];
   int                m_beat;
   logic              m_arvalid;
   logic [ID_W-1:0]   m_arid;
   logic [ADDR_W-1:0] m_araddr;
   logic [7:0]        m_arlen;
   logic [2:0]        m_arsize;
   logic [1:0]        m_arburst;
   logic              m_rsp_valid, m_rsp_last, m_proto;
   logic [ID_W-1:0]   m_rsp_id;
   logic [DATA_W-1:0] m_rsp_data;
   logic [1:0]        m_rsp_resp;
   int                m_errcnt, m_errcnt2;

   // subordinate (stimulus) state
   burst_t sq[$];
   int     s_beat;
   logic   prev_acc;
   logic   r_from_sq;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      mq.delete();
      m_beat = 0; m_arvalid = 1'b0; m_arid = '0; m_araddr = '0; m_arlen = '0;
      m_arsize = '0; m_arburst = '0; m_rsp_valid = 1'b0; m_rsp_last = 1'b0;
      m_proto = 1'b0; m_rsp_id = '0; m_rsp_data = '0; m_rsp_resp = '0;
      m_errcnt = 0; m_errcnt2 = 0;
   endtask

   task automatic idle();
      cmd_valid = 1'b0; ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
      RID = '0; RDATA = '0; RRESP = 2'd0; rsp_ready = 1'b1; err_clear = 1'b0;
      r_from_sq = 1'b0;
   endtask

   // One clock: inputs are already driven; compare, advance model, reach next negedge.
   task automatic step();
      logic   exp_crdy, exp_rrdy, acc_c, acc_r, set;
      burst_t h;
      #1;
      if (!ARESETn) model_reset();
      exp_crdy = !m_arvalid && (mq.size() < MAX_OUTST);
      exp_rrdy = !m_rsp_valid || rsp_ready;
      check("cmd_ready", 64'(cmd_ready), 64'(exp_crdy));
      check("ARVALID",   64'(ARVALID),   64'(m_arvalid));
      check("ARID",      64'(ARID),      64'(m_arid));
      check("ARADDR",    64'(ARADDR),    64'(m_araddr));
      check("ARLEN",     64'(ARLEN),     64'(m_arlen));
      check("ARSIZE",    64'(ARSIZE),    64'(m_arsize));
      check("ARBURST",   64'(ARBURST),   64'(m_arburst));
      check("RREADY",    64'(RREADY),    64'(exp_rrdy));
      check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
      check("rsp_id",    64'(rsp_id),    64'(m_rsp_id));
      check("rsp_data",  64'(rsp_data),  64'(m_rsp_data));
      check("rsp_resp",  64'(rsp_resp),  64'(m_rsp_resp));
      check("rsp_last",  64'(rsp_last),  64'(m_rsp_last));
      check("outst_cnt", 64'(outst_cnt), 64'(mq.size()));
      check("proto_err", 64'(proto_err), 64'(m_proto));
      check("resp_err_cnt", 64'(resp_err_cnt), 64'(m_errcnt));
      check("resp_err_cnt_w2", 64'(s_resp_err_cnt), 64'(m_errcnt2));

      // subordinate bookkeeping from observed handshakes
      if (ARESETn && ARVALID && ARREADY) sq.push_back('{ARID, ARLEN});
      prev_acc = RVALID && RREADY;
      if (prev_acc && r_from_sq && sq.size() > 0) begin
         if (RLAST || s_beat == int'(sq[0].len)) begin
            void'(sq.pop_front());
            s_beat = 0;
         end else begin
            s_beat++;
         end
      end

      if (ARESETn) begin
         acc_c = cmd_valid && exp_crdy;
         acc_r = RVALID && exp_rrdy;
         set   = 1'b0;
         if (acc_r) begin
            if (mq.size() == 0) begin
               set = 1'b1;
            end else begin
               h = mq[0];
               if (RID != h.id) set = 1'b1;
               if (RLAST != (m_beat == int'(h.len))) set = 1'b1;
               if (RLAST || m_beat == int'(h.len)) begin
                  void'(mq.pop_front());
                  m_beat = 0;
               end else begin
                  m_beat++;
               end
            end
         end
         if (acc_c) mq.push_back('{cmd_id, cmd_len});
         if (acc_c) begin
            m_arvalid = 1'b1; m_arid = cmd_id; m_araddr = cmd_addr;
            m_arlen = cmd_len; m_arsize = cmd_size; m_arburst = cmd_burst;
         end else if (m_arvalid && ARREADY) begin
            m_arvalid = 1'b0;
         end
         if (acc_r) begin
            m_rsp_valid = 1'b1; m_rsp_id = RID; m_rsp_data = RDATA;
            m_rsp_resp = RRESP; m_rsp_last = RLAST;
         end else if (rsp_ready) begin
            m_rsp_valid = 1'b0;
         end
         if (err_clear) begin
            m_proto = 1'b0; m_errcnt = 0; m_errcnt2 = 0;
         end else begin
            if (set) m_proto = 1'b1;
            if (acc_r && RRESP[1]) begin
               if (m_errcnt < 65535) m_errcnt++;
               if (m_errcnt2 < 3) m_errcnt2++;
            end
         end
      end
      @(negedge ACLK);
   endtask

   task automatic send_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
      cmd_valid = 1'b1; cmd_id = id; cmd_addr = addr; cmd_len = len;
      cmd_size = 3'd2; cmd_burst = 2'd1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic drive_random();
      cmd_valid = ($urandom_range(0, 9) < 4);
      cmd_id    = 4'($urandom);
      cmd_addr  = $urandom;
      cmd_len   = 8'($urandom_range(0, 5));
      cmd_size  = 3'($urandom);
      cmd_burst = 2'($urandom);
      ARREADY   = 1'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      err_clear = ($urandom_range(0, 99) == 0);
      if (!(RVALID && !prev_acc)) begin
         RVALID = 1'b0; RLAST = 1'b0; r_from_sq = 1'b0;
         if (sq.size() > 0 && $urandom_range(0, 9) < 6) begin
            RVALID = 1'b1; r_from_sq = 1'b1;
            RID = sq[0].id;
            RLAST = (s_beat == int'(sq[0].len));
            case ($urandom_range(0, 39))
               0:       RID = sq[0].id ^ 4'd1;
               1:       RLAST = ~RLAST;
               default: ;
            endcase
         end else if (mq.size() == 0 && sq.size() == 0 && $urandom_range(0, 49) == 0) begin
            RVALID = 1'b1; RID = 4'($urandom); RLAST = 1'($urandom);
         end
         RDATA = $urandom;
         RRESP = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      end
   endtask

   initial begin
      ARESETn = 1'b0;
      cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
      idle();
      model_reset();
      s_beat = 0; prev_acc = 1'b0;
      @(negedge ACLK);
      repeat (3) step();
      check("rst ARVALID", 64'(ARVALID), 64'd0);
      check("rst outst_cnt", 64'(outst_cnt), 64'd0);
      check("rst rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst proto_err", 64'(proto_err), 64'd0);
      ARESETn = 1'b1;
      step();

      // single burst: ARREADY after two held cycles, four beats
      send_cmd(4'd3, 32'h1000, 8'd3);
      check("t1 ARVALID", 64'(ARVALID), 64'd1);
      check("t1 ARADDR", 64'(ARADDR), 64'h1000);
      check("t1 ARID", 64'(ARID), 64'd3);
      check("t1 outst", 64'(outst_cnt), 64'd1);
      check("t1 cmd_ready", 64'(cmd_ready), 64'd0);
      step();
      step();
      check("t1 ARVALID held", 64'(ARVALID), 64'd1);
      ARREADY = 1'b1;
      step();
      ARREADY = 1'b0;
      check("t1 ARVALID drop", 64'(ARVALID), 64'd0);
      for (int i = 0; i < 4; i++) begin
         RVALID = 1'b1; RID = 4'd3; RDATA = 32'hA0 + 32'(i); RRESP = 2'd0; RLAST = (i == 3);
         step();
         check("t1 rsp_valid", 64'(rsp_valid), 64'd1);
         check("t1 rsp_data", 64'(rsp_data), 64'hA0 + 64'(i));
      end
      RVALID = 1'b0; RLAST = 1'b0;
      check("t1 rsp_last", 64'(rsp_last), 64'd1);
      check("t1 outst end", 64'(outst_cnt), 64'd0);
      check("t1 proto_err", 64'(proto_err), 64'd0);
      step();

      // error responses: three SLVERR and one DECERR
      send_cmd(4'd1, 32'h2000, 8'd3);
      ARREADY = 1'b1;
      step();
      ARREADY = 1'b0;
      for (int i = 0; i < 4; i++) begin
         RVALID = 1'b1; RID = 4'd1; RDATA = 32'(i); RRESP = (i == 3) ? 2'b11 : 2'b10;
         RLAST = (i == 3);
         step();
      end
      RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'd0;
      check("t2 resp_err_cnt", 64'(resp_err_cnt), 64'd4);
      check("t2 sat cnt", 64'(s_resp_err_cnt), 64'd3);
      check("t2 proto_err", 64'(proto_err), 64'd0);
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      check("t2 cleared", 64'(resp_err_cnt), 64'd0);

      // beat with nothing outstanding is flagged but forwarded
      RVALID = 1'b1; RID = 4'd5; RDATA = 32'h55; RLAST = 1'b1;
      step();
      RVALID = 1'b0; RLAST = 1'b0;
      check("t3 proto_err", 64'(proto_err), 64'd1);
      check("t3 rsp_id", 64'(rsp_id), 64'd5);
      check("t3 outst", 64'(outst_cnt), 64'd0);
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      check("t3 cleared", 64'(proto_err), 64'd0);

      // randomized traffic with a mid-run reset
      sq.delete(); s_beat = 0; prev_acc = 1'b0; r_from_sq = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         drive_random();
         if (cyc >= 1500 && cyc < 1503) begin
            ARESETn = 1'b0;
            sq.delete(); s_beat = 0;
         end else begin
            ARESETn = 1'b1;
         end
         if (cyc == 1503) begin
            RVALID = 1'b1; RLAST = 1'b0; r_from_sq = 1'b0; RID = 4'd2;
         end
         step();
      end
      idle();
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axi_rd_master_mo.md
Name: axi_rd_master_mo

Overview:
- Parametrised AXI4 read-channel master; successor to the single-burst read FSM.
- Accepts read commands on a valid/ready command port and issues them on AR with handshake-correct ARVALID hold.
- Keeps up to MAX_OUTST bursts in flight and returns R beats on a backpressured response stream.
- Checks each burst's beat count and RID against the issued command. Records protocol and response errors for the wrapper.

Parameters:
- ID_W, 4, AXI ID width
- ADDR_W, 32, AXI address width
- DATA_W, 32, AXI data width; power of 2, 8..1024
- MAX_OUTST, 4, maximum commands accepted but not yet completed; power of 2, 1..16
- ERRCNT_W, 16, width of the saturating error-response counter

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  async active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_id  in  ID_W  ARID to issue
- cmd_addr  in  ADDR_W  ARADDR
- cmd_len  in  8  ARLEN (beats-1)
- cmd_size  in  3  ARSIZE
- cmd_burst  in  2  ARBURST
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  out  ID_W/ADDR_W/8/3/2  AXI AR payload
- ARVALID  out  1  AXI
- ARREADY  in  1  AXI
- RID/RDATA/RRESP  in  ID_W/DATA_W/2  AXI
- RLAST/RVALID  in  1/1  AXI
- RREADY  out  1  AXI
- rsp_valid  out  1  response beat valid
- rsp_ready  in  1  downstream accepts beat
- rsp_id/rsp_data/rsp_resp  out  ID_W/DATA_W/2  registered beat
- rsp_last  out  1  registered beat, last of burst
- outst_cnt  out  $clog2(MAX_OUTST+1)  commands in flight
- proto_err  out  1  sticky protocol error
- err_clear  in  1  clears proto_err and resp_err_cnt
- resp_err_cnt  out  ERRCNT_W  count of beats with RRESP[1]=1, saturating

Behaviour:
- Reset: ARVALID=0, AR payload=0, rsp_valid=0, rsp_* payload=0, outst_cnt=0, proto_err=0, resp_err_cnt=0, tracking FIFO empty, beat counter 0.
- Subordinates used with this block return bursts in issue order. Interleaving across IDs is not supported.
- Interleaved data is flagged as a protocol error.

AR channel:
- Two states: AR_IDLE and AR_BUSY.
- cmd_ready = (state==AR_IDLE) && (outst_cnt < MAX_OUTST). Combinational, no dependence on cmd_valid.
- On cmd accept:
  - Register AR payload and set ARVALID=1 next cycle; go to AR_BUSY.
  - Push {cmd_id, cmd_len} into the tracking FIFO (depth MAX_OUTST).
  - outst_cnt increments.
- In AR_BUSY, ARVALID and payload are held stable until ARREADY=1.
- On the ARREADY cycle, ARVALID drops next cycle and state returns to AR_IDLE.
- Next cmd_ready is the cycle after the handshake, so maximum AR throughput is one command per 2 cycles.

R channel:
- RREADY = !rsp_valid || rsp_ready. This is a one-entry output register, so full R throughput holds when rsp_ready=1.
- R beat accepted when RVALID&RREADY. Its RID/RDATA/RRESP/RLAST appear on rsp_* with rsp_valid=1 the next cycle (latency 1).
- rsp_valid stays 1 until rsp_ready.
- Beat counter counts accepted beats of the FIFO-head burst.
- On each accepted beat, with head = FIFO head:
  - If RID != head.id, set proto_err.
  - If RLAST=1 and beat_cnt != head.len, set proto_err.
  - If RLAST=0 and beat_cnt == head.len, set proto_err.
  - On RLAST=1: pop the FIFO, clear beat_cnt, outst_cnt decrements. Otherwise beat_cnt increments.
- Beat accepted with FIFO empty (outst_cnt=0):
  - Set proto_err.
  - Beat is still forwarded to rsp_*.
  - No pop, and outst_cnt is unchanged.
- Beat whose burst overruns (RLAST=0 at beat_cnt==head.len) is treated as the end of the burst: pop, clear, decrement. This keeps tracking resynchronised.
- Cmd accept and last-beat completion in the same cycle: outst_cnt unchanged, and FIFO push and pop both occur.

Error reporting:
- resp_err_cnt increments on each accepted beat with RRESP[1]=1 (SLVERR or DECERR). Saturates at all-ones.
- err_clear has priority over a same-cycle set or increment: both outputs read 0 next cycle.
- proto_err does not stall the block.

Reset mid-burst:
- All state returns to reset values immediately and the FIFO is flushed.
- Beats still arriving after reset are handled as FIFO-empty beats and set proto_err.

Test Plan:
- Single burst cmd{id=3,addr=0x1000,len=3,INCR}, ARREADY after 2 cycles, 4 R beats RID=3 with RLAST on 4th, rsp_ready=1 -> ARVALID held 3 cycles with stable payload, 4 rsp beats each 1 cycle after its R beat, outst_cnt 1->0, proto_err=0.
- MAX_OUTST=4, 6 back-to-back commands, ARREADY=1, no R traffic -> exactly 4 AR handshakes, cmd_ready=0 with outst_cnt=4. After one burst completes, 5th command accepted.
- rsp_ready=0 for 5 cycles during a len=7 burst with RVALID=1 -> RREADY=0 after the first beat, no beat lost or duplicated, RDATA order preserved.
- Command accepted in the same cycle as the RLAST of the previous burst -> outst_cnt stays 1, next burst tracked against the new FIFO head.
- len=3 burst with RLAST on beat 2; then RID mismatch on the next burst; then R beat with outst_cnt=0 -> proto_err=1 after the first fault, tracking recovers, err_clear gives proto_err=0.
- 3 beats RRESP=2'b10 and 1 beat 2'b11 -> resp_err_cnt=4. With ERRCNT_W=2 it saturates at 3.
